// File: rtl/axi_rd_arbiter_n.sv
// axi_rd_arbiter_n
// ----------------
// Shares one AXI3 read master port (AR + R) among NUM_CLIENTS requesters.
// Exactly one transaction is outstanding at a time. The grant goes to the
// lowest requesting index (RR_MODE=0) or to the first requester at or after
// a rotating pointer (RR_MODE=1). A flush abandons the current transaction
// without breaking the AXI protocol: a pending AR is still completed, and
// the remaining R beats are drained with no client response.
//
// Ports
//   aclk, aresetn         clock, synchronous active-low reset
//   flush                 discard current/pending transaction
//   req_valid/addr/len/size  packed per-client request (client i in slice i)
//   req_ready             one-cycle pulse, the cycle after the AR handshake
//   resp_valid            per-client beat strobe (combinational from R)
//   resp_data/last/err    shared beat data, last flag, error flag
//   ar*                   AXI AR channel (arvalid registered)
//   r*                    AXI R channel (rready registered)
//   dbg_state             current FSM state (0 IDLE, 1 AR, 2 R, 3 DRAIN)
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; once raised, valid and its payload hold until that edge.
module axi_rd_arbiter_n #(
  parameter int NUM_CLIENTS = 2,
  parameter int RR_MODE     = 0,
  parameter int ID_BASE     = 0
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      flush,
  input  logic [NUM_CLIENTS-1:0]    req_valid,
  input  logic [32*NUM_CLIENTS-1:0] req_addr,
  input  logic [4*NUM_CLIENTS-1:0]  req_len,
  input  logic [3*NUM_CLIENTS-1:0]  req_size,
  output logic [NUM_CLIENTS-1:0]    req_ready,
  output logic [NUM_CLIENTS-1:0]    resp_valid,
  output logic [31:0]               resp_data,
  output logic                      resp_last,
  output logic                      resp_err,
  output logic [3:0]                arid,
  output logic [31:0]               araddr,
  output logic [3:0]                arlen,
  output logic [2:0]                arsize,
  output logic [1:0]                arburst,
  output logic [1:0]                arlock,
  output logic [3:0]                arcache,
  output logic [2:0]                arprot,
  output logic                      arvalid,
  input  logic                      arready,
  input  logic [3:0]                rid,
  input  logic [31:0]               rdata,
  input  logic [1:0]                rresp,
  input  logic                      rlast,
  input  logic                      rvalid,
  output logic                      rready,
  output logic [1:0]                dbg_state
);

  localparam int IW = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_AR = 2'd1, S_R = 2'd2, S_DRAIN = 2'd3} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          grant_q, grant_d;
  logic [31:0]            addr_q, addr_d;
  logic [3:0]             len_q, len_d;
  logic [2:0]             size_q, size_d;
  logic                   arvalid_q, arvalid_d;
  logic                   rready_q, rready_d;
  logic [NUM_CLIENTS-1:0] req_ready_q, req_ready_d;
  logic [4:0]             beat_cnt_q, beat_cnt_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic                   flush_seen_q, flush_seen_d;

  logic          gnt_found;
  logic [IW-1:0] gnt_idx;
  int            scan_idx;
  int            sel;
  logic          beat_ok;
  logic          deliver;

  // Arbitration: scan from 0 (fixed) or from the RR pointer with wrap.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = 0;
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      if (RR_MODE != 0) scan_idx = (int'(rr_ptr_q) + k) % NUM_CLIENTS;
      else              scan_idx = k;
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = IW'(scan_idx);
      end
    end
  end

  assign arid    = 4'(ID_BASE + int'(grant_q));
  assign araddr  = addr_q;
  assign arlen   = len_q;
  assign arsize  = size_q;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = arvalid_q;
  assign rready  = rready_q;
  assign req_ready = req_ready_q;
  assign dbg_state = state_q;

  // Beats with a foreign rid are still accepted (rready is high) but ignored.
  assign beat_ok = rvalid && rready_q && (rid == arid);
  assign deliver = (state_q == S_R) && beat_ok && !flush;

  always_comb begin
    resp_valid = '0;
    if (deliver) resp_valid[grant_q] = 1'b1;
    resp_data = rdata;
    resp_last = deliver && rlast;
    // Error when the slave reports one, or when rlast arrives early or late.
    resp_err  = deliver && ((rresp != 2'b00) || (rlast != (beat_cnt_q == {1'b0, len_q})));
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    addr_d       = addr_q;
    len_d        = len_q;
    size_d       = size_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    req_ready_d  = '0;
    beat_cnt_d   = beat_cnt_q;
    rr_ptr_d     = rr_ptr_q;
    flush_seen_d = flush_seen_q;
    sel          = int'(gnt_idx);
    case (state_q)
      S_IDLE: begin
        flush_seen_d = 1'b0;
        if (!flush && gnt_found) begin
          grant_d   = gnt_idx;
          addr_d    = req_addr[32*sel +: 32];
          len_d     = req_len[4*sel +: 4];
          size_d    = req_size[3*sel +: 3];
          arvalid_d = 1'b1;
          state_d   = S_AR;
        end
      end
      S_AR: begin
        if (arvalid_q && arready) begin
          arvalid_d              = 1'b0;
          rready_d               = 1'b1;
          req_ready_d[grant_q]   = 1'b1;
          beat_cnt_d             = '0;
          rr_ptr_d               = (grant_q == IW'(NUM_CLIENTS - 1)) ? '0 : grant_q + 1'b1;
          flush_seen_d           = 1'b0;
          state_d                = (flush_seen_q || flush) ? S_DRAIN : S_R;
        end else if (flush) begin
          // AR cannot be withdrawn; remember the flush for the data phase.
          flush_seen_d = 1'b1;
        end
      end
      S_R: begin
        if (beat_ok) begin
          beat_cnt_d = beat_cnt_q + 5'd1;
          if (rlast) begin
            rready_d = 1'b0;
            state_d  = S_IDLE;
          end
        end
        if (flush && !(beat_ok && rlast)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (beat_ok && rlast) begin
          rready_d = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q      <= S_IDLE;
      grant_q      <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      req_ready_q  <= '0;
      beat_cnt_q   <= '0;
      rr_ptr_q     <= '0;
      flush_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      addr_q       <= addr_d;
      len_q        <= len_d;
      size_q       <= size_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      req_ready_q  <= req_ready_d;
      beat_cnt_q   <= beat_cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      flush_seen_q <= flush_seen_d;
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter_n.sv
// Testbench for axi_rd_arbiter_n: a round-robin instance (3 clients,
// ID_BASE=3) and a fixed-priority instance (2 clients, ID_BASE=0), both
// driven by directed vectors with hand-computed expectations.
module tb_axi_rd_arbiter_n;

  localparam int N  = 3;
  localparam int IB = 3;
  localparam logic [1:0] S_IDLE = 2'd0, S_AR = 2'd1, S_R = 2'd2, S_DRAIN = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic aresetn = 1'b0;
  always #5 clk = ~clk;

  // ---------------- round-robin DUT ----------------
  logic          flush = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [32*N-1:0] req_addr = '0;
  logic [4*N-1:0]  req_len = '0;
  logic [3*N-1:0]  req_size = '0;
  logic [N-1:0]  req_ready, resp_valid;
  logic [31:0]   resp_data;
  logic          resp_last, resp_err;
  logic [3:0]    arid, arlen, arcache;
  logic [31:0]   araddr;
  logic [2:0]    arsize, arprot;
  logic [1:0]    arburst, arlock;
  logic          arvalid, rready;
  logic          arready = 1'b0;
  logic [3:0]    rid = '0;
  logic [31:0]   rdata = '0;
  logic [1:0]    rresp = '0;
  logic          rlast = 1'b0, rvalid = 1'b0;
  logic [1:0]    dbg_state;

  axi_rd_arbiter_n #(.NUM_CLIENTS(N), .RR_MODE(1), .ID_BASE(IB)) u_rr (
    .aclk(clk), .aresetn(aresetn), .flush(flush),
    .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_size(req_size),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_last(resp_last), .resp_err(resp_err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready), .dbg_state(dbg_state)
  );

  // ---------------- fixed-priority DUT ----------------
  logic [1:0]  f_req_valid = '0;
  logic [63:0] f_req_addr = {32'h0000_2000, 32'h0000_1000};
  logic [7:0]  f_req_len = '0;
  logic [5:0]  f_req_size = {3'd2, 3'd2};
  logic [1:0]  f_req_ready, f_resp_valid;
  logic [31:0] f_resp_data;
  logic        f_resp_last, f_resp_err;
  logic [3:0]  f_arid, f_arlen, f_arcache;
  logic [31:0] f_araddr;
  logic [2:0]  f_arsize, f_arprot;
  logic [1:0]  f_arburst, f_arlock;
  logic        f_arvalid, f_rready;
  logic        f_arready = 1'b0;
  logic [3:0]  f_rid = '0;
  logic [31:0] f_rdata = '0;
  logic [1:0]  f_rresp = '0;
  logic        f_rlast = 1'b0, f_rvalid = 1'b0;
  logic [1:0]  f_dbg_state;

  axi_rd_arbiter_n #(.NUM_CLIENTS(2), .RR_MODE(0), .ID_BASE(0)) u_fp (
    .aclk(clk), .aresetn(aresetn), .flush(1'b0),
    .req_valid(f_req_valid), .req_addr(f_req_addr), .req_len(f_req_len), .req_size(f_req_size),
    .req_ready(f_req_ready), .resp_valid(f_resp_valid), .resp_data(f_resp_data),
    .resp_last(f_resp_last), .resp_err(f_resp_err),
    .arid(f_arid), .araddr(f_araddr), .arlen(f_arlen), .arsize(f_arsize),
    .arburst(f_arburst), .arlock(f_arlock), .arcache(f_arcache), .arprot(f_arprot),
    .arvalid(f_arvalid), .arready(f_arready),
    .rid(f_rid), .rdata(f_rdata), .rresp(f_rresp), .rlast(f_rlast), .rvalid(f_rvalid),
    .rready(f_rready), .dbg_state(f_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [31:0] addrs [N] = '{32'h1FC0_0000, 32'h0000_4000, 32'h8000_0100};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    tick(); tick();
    aresetn = 1'b1;
  endtask

  // Wait for AR, check its fields, optionally stall (flushing on the first
  // stall cycle), complete the handshake and check the post-handshake state.
  task automatic do_ar(input int cl, input logic [31:0] addr, input logic [3:0] len,
                       input int stall, input bit fl, input logic [1:0] exp_st, input bit drop);
    int n;
    n = 0;
    while (!arvalid && n < 20) begin tick(); n++; end
    check_eq("arvalid_up", arvalid, 1);
    check_eq("arid", arid, 32'(IB + cl));
    check_eq("araddr", araddr, addr);
    check_eq("arlen", arlen, len);
    check_eq("arsize", arsize, 2);
    for (int s = 0; s < stall; s++) begin
      flush = fl && (s == 0);
      tick();
      flush = 1'b0;
      check_eq("ar_hold_valid", arvalid, 1);
      check_eq("ar_hold_addr", araddr, addr);
    end
    arready = 1'b1;
    tick();
    arready = 1'b0;
    check_eq("req_ready", req_ready, 32'(1 << cl));
    check_eq("rready_up", rready, 1);
    check_eq("arvalid_down", arvalid, 0);
    check_eq("state_after_ar", dbg_state, exp_st);
    if (drop) req_valid[cl] = 1'b0;
  endtask

  task automatic r_beat(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp,
                        input logic last, input logic fl, input logic [2:0] ev,
                        input logic el, input logic ee);
    rvalid = 1'b1; rid = id; rdata = data; rresp = resp; rlast = last; flush = fl;
    #1;
    check_eq("beat_rready", rready, 1);
    check_eq("resp_valid", resp_valid, ev);
    check_eq("resp_last", resp_last, el);
    check_eq("resp_err", resp_err, ee);
    if (ev != 0) check_eq("resp_data", resp_data, data);
    tick();
    rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00; flush = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < N; i++) begin
      req_addr[32*i +: 32] = addrs[i];
      req_size[3*i +: 3]   = 3'd2;
    end
    do_reset();
    check_eq("rst_state", dbg_state, S_IDLE);
    check_eq("rst_arvalid", arvalid, 0);
    check_eq("rst_rready", rready, 0);
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_resp_valid", resp_valid, 0);
    check_eq("rst_resp_last", resp_last, 0);
    check_eq("rst_resp_err", resp_err, 0);
    check_eq("rst_fp_arvalid", f_arvalid, 0);
    check_eq("arburst", arburst, 1);
    check_eq("arcache_lock_prot", {arcache, arlock, arprot}, 0);

    // Single client 0, single beat.
    req_len[3:0] = 4'd0;
    req_valid    = 3'b001;
    do_ar(0, addrs[0], 0, 0, 0, S_R, 1);
    r_beat(4'(IB), 32'hDEAD_BEEF, 2'b00, 1, 0, 3'b001, 1, 0);
    check_eq("single_idle", dbg_state, S_IDLE);
    check_eq("single_rready_down", rready, 0);

    // Round robin, all clients requesting, 4-beat bursts: 0,1,2,0.
    do_reset();
    for (int i = 0; i < N; i++) req_len[4*i +: 4] = 4'd3;
    req_valid = 3'b111;
    for (int g = 0; g < 4; g++) begin
      do_ar(g % N, addrs[g % N], 3, 0, 0, S_R, 0);
      for (int b = 0; b < 4; b++)
        r_beat(4'(IB + g % N), 32'h100 * g + b, 2'b00, b == 3, 0, 3'(1 << (g % N)), b == 3, 0);
      check_eq("rr_idle", dbg_state, S_IDLE);
    end
    req_valid = 3'b000;

    // Flush during a stalled AR: AR completes, burst drained silently.
    req_valid = 3'b010;
    do_ar(1, addrs[1], 3, 4, 1, S_DRAIN, 1);
    for (int b = 0; b < 4; b++)
      r_beat(4'(IB + 1), 32'hA0 + b, 2'b00, b == 3, 0, 3'b000, 0, 0);
    check_eq("arflush_idle", dbg_state, S_IDLE);

    // Flush on beat 2 of 8; client 0 waits until rlast.
    req_len[11:8] = 4'd7;
    req_len[3:0]  = 4'd0;
    req_valid     = 3'b100;
    do_ar(2, addrs[2], 7, 0, 0, S_R, 1);
    req_valid = 3'b001;
    r_beat(4'(IB + 2), 32'hB0, 2'b00, 0, 0, 3'b100, 0, 0);
    r_beat(4'(IB + 2), 32'hB1, 2'b00, 0, 0, 3'b100, 0, 0);
    r_beat(4'(IB + 2), 32'hB2, 2'b00, 0, 1, 3'b000, 0, 0);
    check_eq("rflush_drain", dbg_state, S_DRAIN);
    for (int b = 3; b < 7; b++) r_beat(4'(IB + 2), 32'hB0 + b, 2'b00, 0, 0, 3'b000, 0, 0);
    r_beat(4'hF, 32'hEE, 2'b00, 1, 0, 3'b000, 0, 0);
    check_eq("drain_foreign_last", dbg_state, S_DRAIN);
    check_eq("drain_no_grant", arvalid, 0);
    r_beat(4'(IB + 2), 32'hB7, 2'b00, 1, 0, 3'b000, 0, 0);
    check_eq("drain_idle", dbg_state, S_IDLE);
    check_eq("drain_arvalid", arvalid, 0);
    do_ar(0, addrs[0], 0, 0, 0, S_R, 1);
    r_beat(4'(IB), 32'hC0, 2'b00, 1, 0, 3'b001, 1, 0);

    // Flush in IDLE blocks the grant; then error cases on a 4-beat burst.
    req_len[3:0] = 4'd3;
    req_valid    = 3'b001;
    flush        = 1'b1;
    tick();
    flush = 1'b0;
    check_eq("idle_flush_no_ar", arvalid, 0);
    check_eq("idle_flush_state", dbg_state, S_IDLE);
    do_ar(0, addrs[0], 3, 0, 0, S_R, 1);
    r_beat(4'h9, 32'hD9, 2'b00, 0, 0, 3'b000, 0, 0);
    r_beat(4'(IB), 32'hD0, 2'b00, 0, 0, 3'b001, 0, 0);
    r_beat(4'(IB), 32'hD1, 2'b10, 0, 0, 3'b001, 0, 1);
    r_beat(4'(IB), 32'hD2, 2'b00, 1, 0, 3'b001, 1, 1);
    check_eq("err_idle", dbg_state, S_IDLE);

    // Reset while AR is pending.
    req_valid = 3'b010;
    tick();
    check_eq("pre_rst_arvalid", arvalid, 1);
    aresetn = 1'b0;
    tick();
    aresetn   = 1'b1;
    req_valid = 3'b000;
    check_eq("mid_rst_arvalid", arvalid, 0);
    check_eq("mid_rst_state", dbg_state, S_IDLE);

    // Fixed priority: client 0 always wins, client 1 starves.
    f_req_valid = 2'b11;
    for (int g = 0; g < 2; g++) begin
      int n;
      n = 0;
      while (!f_arvalid && n < 10) begin tick(); n++; end
      check_eq("fp_arvalid", f_arvalid, 1);
      check_eq("fp_arid", f_arid, 0);
      for (int s = 0; s < 5; s++) begin
        tick();
        check_eq("fp_hold_valid", f_arvalid, 1);
        check_eq("fp_hold_addr", f_araddr, 32'h0000_1000);
      end
      f_arready = 1'b1;
      tick();
      f_arready = 1'b0;
      check_eq("fp_req_ready", f_req_ready, 2'b01);
      f_rvalid = 1'b1; f_rlast = 1'b1; f_rid = 4'd0; f_rdata = 32'h55 + g;
      #1;
      check_eq("fp_resp_valid", f_resp_valid, 2'b01);
      check_eq("fp_resp_data", f_resp_data, 32'h55 + g);
      tick();
      f_rvalid = 1'b0; f_rlast = 1'b0;
      check_eq("fp_idle", f_dbg_state, S_IDLE);
    end
    f_req_valid = 2'b00;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Overall time bound.
  initial begin
    #200000;
    $display("FAIL timeout got=0x0 exp=0x1");
    $fatal(1, "timeout");
  end

endmodule
